// File: rtl/pr_pkg.sv
// Shared types and helpers for the multi-lane ID-stage pipeline register.
// Lane fields are stored at a fixed maximum width and trimmed to DATA_W at the ports.
package pr_pkg;

  localparam int PR_W_MAX     = 64;
  localparam int PR_LANES_MAX = 4;
  localparam int PR_EXT_W     = PR_W_MAX * PR_LANES_MAX;

  localparam logic [PR_W_MAX-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic                valid;
    logic [PR_W_MAX-1:0] rs;
    logic [PR_W_MAX-1:0] rt;
    logic [PR_W_MAX-1:0] instr;
    logic [PR_W_MAX-1:0] pc;
  } pr_lane_t;

  // Extract lane k of a bus whose lanes are w bits wide, zero-extended to PR_W_MAX.
  function automatic logic [PR_W_MAX-1:0] pr_lane_get(input logic [PR_EXT_W-1:0] bus,
                                                      input int k, input int w);
    logic [PR_EXT_W-1:0] w_mask;
    logic [PR_EXT_W-1:0] w_sh;
    w_mask = '1;
    w_mask = ~(w_mask << w);
    w_sh   = (bus >> (k * w)) & w_mask;
    return w_sh[PR_W_MAX-1:0];
  endfunction

  function automatic pr_lane_t pr_lane_make(input logic valid,
                                            input logic [PR_EXT_W-1:0] rs,
                                            input logic [PR_EXT_W-1:0] rt,
                                            input logic [PR_EXT_W-1:0] instr,
                                            input logic [PR_EXT_W-1:0] pc,
                                            input int k, input int w);
    pr_lane_t w_l;
    w_l.valid = valid;
    w_l.rs    = pr_lane_get(rs, k, w);
    w_l.rt    = pr_lane_get(rt, k, w);
    w_l.instr = pr_lane_get(instr, k, w);
    w_l.pc    = pr_lane_get(pc, k, w);
    return w_l;
  endfunction

endpackage

// File: rtl/pr_skid_slot.sv
// One bundle register: clear beats load beats squash. A squash that leaves no
// valid lane empties the whole slot so its data reads as zero.
module pr_skid_slot
  import pr_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_clear,
  input  logic [LANES-1:0]      i_squash_mask,
  input  pr_lane_t [LANES-1:0]  i_d,
  output pr_lane_t [LANES-1:0]  o_q,
  output logic                  o_full
);

  pr_lane_t [LANES-1:0] r_q;
  pr_lane_t [LANES-1:0] w_squashed;
  logic [LANES-1:0]     w_valid;
  logic [LANES-1:0]     w_keep;

  always_comb begin
    w_squashed = r_q;
    for (int k = 0; k < LANES; k++) begin
      w_valid[k] = r_q[k].valid;
      if (i_squash_mask[k]) begin
        w_squashed[k].valid = 1'b0;
        w_squashed[k].instr = NOP_INSTR;
      end
    end
    w_keep = w_valid & ~i_squash_mask;
    if (w_keep == '0) begin
      w_squashed = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (i_clear) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end else if (|i_squash_mask) begin
      r_q <= w_squashed;
    end
  end

  assign o_q    = r_q;
  assign o_full = |w_valid;

endmodule

// File: rtl/pr_id_lanes.sv
// Multi-lane decode-to-issue pipeline register: main slot drives the outputs,
// a skid slot absorbs one bundle so in_ready is a pure flop.
module pr_id_lanes
  import pr_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_lane_valid,
  input  logic [LANES*DATA_W-1:0] in_rs_data,
  input  logic [LANES*DATA_W-1:0] in_rt_data,
  input  logic [LANES*DATA_W-1:0] in_instr,
  input  logic [LANES*DATA_W-1:0] in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_lane_valid,
  output logic [LANES*DATA_W-1:0] out_rs_data,
  output logic [LANES*DATA_W-1:0] out_rt_data,
  output logic [LANES*DATA_W-1:0] out_instr,
  output logic [LANES*DATA_W-1:0] out_pc,
  input  logic                    flush,
  input  logic [LANES-1:0]        squash_mask,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam int BUS_W = LANES * DATA_W;

  logic [PR_EXT_W-1:0]  w_rs_ext, w_rt_ext, w_instr_ext, w_pc_ext;
  pr_lane_t [LANES-1:0] w_in_lanes;
  pr_lane_t [LANES-1:0] w_main_d;
  pr_lane_t [LANES-1:0] w_main_q;
  pr_lane_t [LANES-1:0] w_skid_q;
  logic                 w_main_full, w_skid_full, w_skid_full_nxt;
  logic                 w_fire, w_keep_in, w_main_adv;
  logic                 w_main_load, w_main_clear, w_skid_load, w_skid_clear;
  logic [LANES-1:0]     w_squash;
  logic                 w_unused_main;
  logic                 r_in_ready;
  logic [CNT_W-1:0]     r_stall_cnt;

  always_comb begin
    w_rs_ext    = '0;
    w_rt_ext    = '0;
    w_instr_ext = '0;
    w_pc_ext    = '0;
    w_rs_ext[BUS_W-1:0]    = in_rs_data;
    w_rt_ext[BUS_W-1:0]    = in_rt_data;
    w_instr_ext[BUS_W-1:0] = in_instr;
    w_pc_ext[BUS_W-1:0]    = in_pc;
    for (int k = 0; k < LANES; k++) begin
      w_in_lanes[k] = pr_lane_make(in_lane_valid[k], w_rs_ext, w_rt_ext,
                                   w_instr_ext, w_pc_ext, k, DATA_W);
    end
  end

  // All-invalid bundles are accepted but never stored; flush drops the fired bundle.
  assign w_fire     = in_valid && r_in_ready;
  assign w_keep_in  = w_fire && (|in_lane_valid) && !flush;
  assign w_main_adv = !w_main_full || out_ready;

  always_comb begin
    w_main_load     = 1'b0;
    w_main_clear    = 1'b0;
    w_skid_load     = 1'b0;
    w_skid_clear    = 1'b0;
    w_squash        = '0;
    w_main_d        = w_in_lanes;
    w_skid_full_nxt = w_skid_full;
    if (flush) begin
      w_main_clear    = 1'b1;
      w_skid_clear    = 1'b1;
      w_skid_full_nxt = 1'b0;
    end else if (w_main_adv) begin
      if (w_skid_full) begin
        w_main_load     = 1'b1;
        w_main_d        = w_skid_q;
        w_skid_load     = w_keep_in;
        w_skid_clear    = !w_keep_in;
        w_skid_full_nxt = w_keep_in;
      end else if (w_keep_in) begin
        w_main_load = 1'b1;
      end else begin
        w_main_clear = 1'b1;
      end
    end else begin
      w_squash = squash_mask;
      if (w_keep_in) begin
        w_skid_load     = 1'b1;
        w_skid_full_nxt = 1'b1;
      end
    end
  end

  pr_skid_slot #(.LANES(LANES)) u_main (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_main_load),
    .i_clear      (w_main_clear),
    .i_squash_mask(w_squash),
    .i_d          (w_main_d),
    .o_q          (w_main_q),
    .o_full       (w_main_full)
  );

  pr_skid_slot #(.LANES(LANES)) u_skid (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_skid_load),
    .i_clear      (w_skid_clear),
    .i_squash_mask({LANES{1'b0}}),
    .i_d          (w_in_lanes),
    .o_q          (w_skid_q),
    .o_full       (w_skid_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_ready  <= 1'b1;
      r_stall_cnt <= '0;
    end else begin
      r_in_ready <= !w_skid_full_nxt;
      if (w_main_full && !out_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  // Lane fields are held at PR_W_MAX; only the low DATA_W bits reach the ports.
  assign w_unused_main = ^w_main_q;

  for (genvar g = 0; g < LANES; g++) begin : g_out
    assign out_lane_valid[g]                  = w_main_q[g].valid;
    assign out_rs_data[g*DATA_W +: DATA_W]    = w_main_q[g].rs[DATA_W-1:0];
    assign out_rt_data[g*DATA_W +: DATA_W]    = w_main_q[g].rt[DATA_W-1:0];
    assign out_instr[g*DATA_W +: DATA_W]      = w_main_q[g].instr[DATA_W-1:0];
    assign out_pc[g*DATA_W +: DATA_W]         = w_main_q[g].pc[DATA_W-1:0];
  end

  assign out_valid = w_main_full;
  assign in_ready  = r_in_ready;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pr_id_lanes.sv
// Bench for pr_id_lanes: directed scenarios plus a random run against a FIFO model.
module tb_pr_id_lanes;

  localparam int LANES  = 2;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int BW     = LANES * DATA_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready;
  logic [LANES-1:0] in_lane_valid;
  logic [BW-1:0]    in_rs_data, in_rt_data, in_instr, in_pc;
  logic             out_valid, out_ready;
  logic [LANES-1:0] out_lane_valid;
  logic [BW-1:0]    out_rs_data, out_rt_data, out_instr, out_pc;
  logic             flush;
  logic [LANES-1:0] squash_mask;
  logic [CNT_W-1:0] stall_cnt;

  pr_id_lanes #(.LANES(LANES), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_lane_valid(in_lane_valid),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane_valid(out_lane_valid),
    .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_instr(out_instr),
    .out_pc(out_pc), .flush(flush), .squash_mask(squash_mask), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LANES-1:0] lv;
    logic [BW-1:0]    rs;
    logic [BW-1:0]    rt;
    logic [BW-1:0]    instr;
    logic [BW-1:0]    pc;
  } bnd_t;

  // q[0] is the main slot (lv==0 there means emptied by squash), q[1] the skid.
  bnd_t q[$];
  int   m_stall;
  logic m_in_ready;
  int   n_checks;
  int   n_fail;

  function automatic bnd_t front();
    if (q.size() > 0 && q[0].lv != '0) return q[0];
    return '0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_stall    = 0;
    m_in_ready = 1'b1;
  endtask

  task automatic drive(input logic v, input logic [LANES-1:0] lv, input logic [BW-1:0] pc);
    in_valid      = v;
    in_lane_valid = lv;
    in_pc         = pc;
    in_rs_data    = {$urandom, $urandom};
    in_rt_data    = {$urandom, $urandom};
    in_instr      = {$urandom, $urandom};
  endtask

  task automatic tick();
    bnd_t b;
    logic fire, ov;
    @(posedge clk);
    ov   = (q.size() > 0) && (q[0].lv != '0);
    fire = in_valid && m_in_ready;
    if (ov && !out_ready && m_stall < (2**CNT_W - 1)) m_stall++;
    if (flush) begin
      q.delete();
    end else begin
      if (q.size() > 0 && (q[0].lv == '0 || out_ready)) begin
        void'(q.pop_front());
      end else if (ov && squash_mask != '0) begin
        b    = q[0];
        b.lv = b.lv & ~squash_mask;
        for (int k = 0; k < LANES; k++)
          if (squash_mask[k]) b.instr[k*DATA_W +: DATA_W] = '0;
        if (b.lv == '0) b = '0;
        q[0] = b;
      end
      if (fire && in_lane_valid != '0) begin
        b.lv = in_lane_valid; b.rs = in_rs_data; b.rt = in_rt_data;
        b.instr = in_instr; b.pc = in_pc;
        q.push_back(b);
      end
    end
    m_in_ready = (q.size() < 2);
    #1;
  endtask

  task automatic reset_dut();
    reset       = 1'b0;
    out_ready   = 1'b0;
    flush       = 1'b0;
    squash_mask = '0;
    drive(1'b0, '0, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_dut();
    n_checks++;
    if ({out_valid, out_lane_valid, out_rs_data, out_rt_data, out_instr, out_pc} !== '0) begin
      n_fail++; $display("FAIL reset_outputs actual=%0h expected=0", {out_valid, out_lane_valid, out_pc});
    end
    n_checks++;
    if (in_ready !== 1'b1 || stall_cnt !== '0) begin
      n_fail++; $display("FAIL reset_ready_cnt actual=%b/%0d expected=1/0", in_ready, stall_cnt);
    end
  endtask

  task automatic test_streaming();
    logic [BW-1:0] pcs [2];
    pcs[0] = 64'h0000_0104_0000_0100;
    pcs[1] = 64'h0000_010C_0000_0108;
    reset_dut();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'b11, pcs[i]);
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== pcs[i] || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL stream_%0d actual=%b/%h/%b expected=1/%h/1", i, out_valid, out_pc, in_ready, pcs[i]);
      end
      n_checks++;
      if ({out_lane_valid, out_rs_data, out_rt_data, out_instr, out_pc} !== front()) begin
        n_fail++; $display("FAIL stream_data_%0d actual=%h expected=%h", i, out_rs_data, front().rs);
      end
    end
    drive(1'b0, '0, '0);
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_pc !== '0) begin
      n_fail++; $display("FAIL stream_drain actual=%b/%h expected=0/0", out_valid, out_pc);
    end
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] exp_pc [5];
    logic          exp_rdy [5];
    int            exp_cnt [5];
    exp_pc[0] = 64'h204_0000_0200; exp_rdy[0] = 1'b1; exp_cnt[0] = 0;
    exp_pc[1] = 64'h204_0000_0200; exp_rdy[1] = 1'b0; exp_cnt[1] = 1;
    exp_pc[2] = 64'h204_0000_0200; exp_rdy[2] = 1'b0; exp_cnt[2] = 2;
    exp_pc[3] = 64'h20C_0000_0208; exp_rdy[3] = 1'b1; exp_cnt[3] = 2;
    exp_pc[4] = 64'h214_0000_0210; exp_rdy[4] = 1'b1; exp_cnt[4] = 2;
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1'b1, 2'b11, {32'h204 + 32'(8*i), 32'h200 + 32'(8*i)});
      out_ready = (i >= 3);
      tick();
      n_checks++;
      if (out_pc !== exp_pc[i] || in_ready !== exp_rdy[i] || stall_cnt !== CNT_W'(exp_cnt[i])) begin
        n_fail++; $display("FAIL backpressure_%0d actual=%h/%b/%0d expected=%h/%b/%0d",
                           i, out_pc, in_ready, stall_cnt, exp_pc[i], exp_rdy[i], exp_cnt[i]);
      end
      n_checks++;
      if ({out_lane_valid, out_rs_data, out_rt_data, out_instr, out_pc} !== front()) begin
        n_fail++; $display("FAIL backpressure_model_%0d actual=%h expected=%h", i, out_pc, front().pc);
      end
      if (i == 4) in_valid = 1'b0;
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL backpressure_drain actual=%b expected=0", out_valid);
    end
  endtask

  task automatic test_flush();
    reset_dut();
    drive(1'b1, 2'b11, 64'h304_0000_0300); tick();
    drive(1'b1, 2'b01, 64'h30C_0000_0308); tick();
    drive(1'b1, 2'b11, 64'h314_0000_0310);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if ({out_valid, out_lane_valid, out_rs_data, out_rt_data, out_instr, out_pc} !== '0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_collision actual=%b/%h/%b expected=0/0/1", out_valid, out_pc, in_ready);
    end
    out_ready = 1'b1;
    drive(1'b1, 2'b10, 64'h31C_0000_0318);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_pc !== '0) begin
      n_fail++; $display("FAIL flush_discard actual=%b/%h expected=0/0", out_valid, out_pc);
    end
  endtask

  task automatic test_squash();
    logic [BW-1:0] a_instr;
    reset_dut();
    drive(1'b1, 2'b11, 64'h404_0000_0400);
    a_instr = in_instr;
    tick();
    drive(1'b1, 2'b11, 64'h40C_0000_0408); tick();
    drive(1'b0, '0, '0);
    squash_mask = 2'b10;
    tick();
    n_checks++;
    if (out_lane_valid !== 2'b01 || out_instr !== {32'h0, a_instr[31:0]} || out_pc !== 64'h404_0000_0400) begin
      n_fail++; $display("FAIL squash_lane1 actual=%b/%h expected=01/%h", out_lane_valid, out_instr, {32'h0, a_instr[31:0]});
    end
    squash_mask = 2'b01;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_instr !== '0) begin
      n_fail++; $display("FAIL squash_all actual=%b/%h expected=0/0", out_valid, out_instr);
    end
    squash_mask = '0;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h40C_0000_0408 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL squash_advance actual=%b/%h/%b expected=1/40c00000408/1", out_valid, out_pc, in_ready);
    end
  endtask

  task automatic test_bubble_saturation();
    reset_dut();
    out_ready = 1'b1;
    drive(1'b1, 2'b00, 64'h504_0000_0500);
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_pc !== '0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bubble actual=%b/%h/%b expected=0/0/1", out_valid, out_pc, in_ready);
    end
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 64'h50C_0000_0508);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    n_checks++;
    if (stall_cnt !== 4'd15) begin
      n_fail++; $display("FAIL stall_saturate actual=%0d expected=15", stall_cnt);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 2'b11, 64'h604_0000_0600);
    tick();
    in_valid = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_lane_valid, out_rs_data, out_rt_data, out_instr, out_pc} !== '0 ||
        in_ready !== 1'b1 || stall_cnt !== '0) begin
      n_fail++; $display("FAIL async_reset actual=%b/%h/%b/%0d expected=0/0/1/0", out_valid, out_pc, in_ready, stall_cnt);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, LANES'($urandom), {$urandom, $urandom});
      out_ready   = ($urandom % 3) != 0;
      flush       = ($urandom % 20) == 0;
      squash_mask = (($urandom % 4) == 0) ? LANES'($urandom) : '0;
      tick();
      n_checks++;
      if ({out_lane_valid, out_rs_data, out_rt_data, out_instr, out_pc} !== front() ||
          out_valid !== (front().lv != '0)) begin
        n_fail++; $display("FAIL random_data_%0d actual=%b/%h expected=%b/%h", i, out_lane_valid, out_pc, front().lv, front().pc);
      end
      n_checks++;
      if (in_ready !== m_in_ready || stall_cnt !== CNT_W'(m_stall)) begin
        n_fail++; $display("FAIL random_ctrl_%0d actual=%b/%0d expected=%b/%0d", i, in_ready, stall_cnt, m_in_ready, m_stall);
      end
    end
    flush = 1'b0;
    squash_mask = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_squash();
    test_bubble_saturation();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pr_id_lanes.md
Name: pr_id_lanes

Overview:
- Parametrised, multi-lane successor to the single-issue ID-stage pipeline register for the superscalar 8-stage MIPS core.
- Carries LANES parallel instruction slots (rs data, rt data, instr, pc plus a valid bit per lane) from decode to the next stage.
- Uses a valid/ready handshake with a 2-slot skid buffer, so backpressure never forms a combinational ready path.
- Adds flush, per-lane squash and a saturating stall counter for performance analysis.

Parameters:
- LANES, 2, number of issue lanes carried per bundle (1..4)
- DATA_W, 32, width of each of rs_data, rt_data, instr, pc
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream bundle present
- in_ready  out  1  block can accept a bundle this cycle (registered)
- in_lane_valid  in  LANES  per-lane valid of the incoming bundle
- in_rs_data  in  LANES*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W]; same packing for the next three ports
- in_rt_data  in  LANES*DATA_W
- in_instr  in  LANES*DATA_W
- in_pc  in  LANES*DATA_W
- out_valid  out  1  held bundle has at least one valid lane
- out_ready  in  1  downstream consumes the bundle
- out_lane_valid  out  LANES  per-lane valid of the held bundle
- out_rs_data, out_rt_data, out_instr, out_pc  out  LANES*DATA_W each  held bundle fields
- flush  in  1  synchronous kill of all stored bundles
- squash_mask  in  LANES  clear the selected lanes of the held (output) bundle
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (reset=0, asynchronous): all data outputs 0, out_lane_valid=0, out_valid=0, skid empty, in_ready=1, stall_cnt=0.
- Storage: a main slot drives the outputs; a skid slot holds one younger bundle. in_ready is registered and equals !skid_full.
- Accept: fire = in_valid && in_ready.
- A bundle with in_lane_valid=0 is accepted and discarded (bubble). It is never stored.
- Main-slot update order, applied when the main slot is empty or out_ready=1:
  - skid full: main <= skid, skid empties, and any fired bundle goes into skid.
  - skid empty: main <= fired bundle if one fired; otherwise main becomes empty.
- Main full, out_ready=0 and fire: bundle goes into skid. in_ready=0 from the next cycle.
- Latency: 1 cycle from in to out when unstalled. Throughput: 1 bundle per cycle.
- Empty main slot: all lane valids and all data read as 0. instr=0 is the NOP encoding.
- flush=1 has priority over everything:
  - Next cycle both slots are empty, all data is zeroed and in_ready=1.
  - A bundle fired in the same cycle as flush is discarded.
- squash_mask:
  - Applied only while the main bundle is held (out_valid && !out_ready).
  - Clears the selected lane valid bits and zeroes their instr field on the next edge.
  - If every lane becomes invalid, out_valid drops and the slot counts as empty, so the skid bundle advances on the following edge.
  - Ignored when out_ready=1 or when flush=1.
- Lane ordering: lane 0 is oldest. Lanes are never reordered or compacted.
- stall_cnt increments each cycle that out_valid && !out_ready. It saturates at 2^CNT_W-1, is cleared only by reset and is unaffected by flush.
- Reset asserted mid-stall: returns to the reset state immediately and loses all bundles.

Decomposition:
- Shared package pr_pkg holds:
  - the lane-bundle typedef (rs, rt, instr, pc, valid)
  - NOP_INSTR = 0
  - a packing helper function for lane k slices
- One sub-module, pr_skid_slot: a single bundle register with load, clear and squash-mask inputs. It is instantiated twice, as the main slot and the skid slot.

Test Plan:
- Streaming: LANES=2, out_ready=1; bundles with pc 0x100/0x104, then 0x108/0x10C, on consecutive cycles. Each appears exactly 1 cycle later and in_ready stays 1.
- Backpressure: out_ready=0 while 3 bundles are offered (A, B, C).
  - A is held; B goes into skid; in_ready=0 after B, and C is not accepted.
  - stall_cnt increments by 1 per stalled cycle.
  - Releasing out_ready yields A, B, C in order with no loss or duplication.
- Flush collision: skid full, flush=1 with in_valid=1 on the same cycle. Next cycle out_valid=0, all outputs 0, in_ready=1, and the incoming bundle never appears.
- Squash:
  - Held bundle with lane_valid=2'b11, squash_mask=2'b10: next cycle out_lane_valid=2'b01, lane 1 instr=0, lane 0 unchanged.
  - Then squash_mask=2'b01: out_valid=0 and the skid bundle advances.
- Bubble and saturation: in_lane_valid=0 with in_valid=1 produces no output. With CNT_W=4 and 20 stall cycles, stall_cnt=15.
- Async reset: assert reset=0 mid-stall between clock edges. Outputs are 0 and in_ready=1 immediately, with no clock edge required.
